// File: rtl/alu_mul_sequencer.sv
// Shift-add multiply sequencer that borrows the shared ALU (ADD/SHL) to form the
// low XLEN bits of a*b. It requests the ALU with alu_req/alu_gnt and returns the product over valid/ready.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for an operand pair
// EVAL  | pick next step from mplier/cnt, ALU untouched
// ADD   | acc <= acc + mcand through the ALU (stalls without grant)
// SHIFT | mcand <= mcand << 1 through the ALU, mplier >>= 1, cnt++
// DONE  | hold product on resp_data until resp_ready
module alu_mul_sequencer #(
  parameter int         XLEN     = 32,
  parameter logic [2:0] CTRL_ADD = 3'b000,
  parameter logic [2:0] CTRL_SHL = 3'b001
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            alu_req,
  input  logic            alu_gnt,
  output logic [XLEN-1:0] alu_srca,
  output logic [XLEN-1:0] alu_srcb,
  output logic [2:0]      alu_ctrl,
  input  logic [XLEN-1:0] alu_result
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(XLEN);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EVAL  = 3'd1,
    S_ADD   = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] acc, mcand, mplier;
  logic [CW-1:0]   cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ALU drives depend only on state and registers; alu_gnt only steers the next state.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_data  = '0;
    alu_req    = 1'b0;
    alu_srca   = '0;
    alu_srcb   = '0;
    alu_ctrl   = CTRL_ADD;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = S_EVAL;
      end
      S_EVAL: begin
        if (mplier == '0 || cnt == CNT_MAX) state_next = S_DONE;
        else if (mplier[0])                 state_next = S_ADD;
        else                                state_next = S_SHIFT;
      end
      S_ADD: begin
        alu_req  = 1'b1;
        alu_srca = acc;
        alu_srcb = mcand;
        alu_ctrl = CTRL_ADD;
        if (alu_gnt) state_next = S_SHIFT;
      end
      S_SHIFT: begin
        alu_req  = 1'b1;
        alu_srca = mcand;
        alu_srcb = XLEN'(1);
        alu_ctrl = CTRL_SHL;
        if (alu_gnt) state_next = S_EVAL;
      end
      S_DONE: begin
        resp_valid = 1'b1;
        resp_data  = acc;
        if (resp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            acc    <= '0;
            mcand  <= req_a;
            mplier <= req_b;
            cnt    <= '0;
          end
        end
        S_ADD: begin
          if (alu_gnt) acc <= alu_result;
        end
        S_SHIFT: begin
          if (alu_gnt) begin
            mcand  <= alu_result;
            mplier <= {1'b0, mplier[XLEN-1:1]};
            cnt    <= cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: a behavioural ALU model, a vector table, corner-case
// sequences and randomized operands compared against a*b.
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_data;
  logic        alu_req;
  logic        alu_gnt = 1'b1;
  logic [31:0] alu_srca;
  logic [31:0] alu_srcb;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_result;

  int n_pass = 0;
  int n_total = 0;

  alu_mul_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_srca(alu_srca), .alu_srcb(alu_srcb),
    .alu_ctrl(alu_ctrl), .alu_result(alu_result)
  );

  always #5 clk = ~clk;

  // Shared ALU model: only ADD and SHL matter here.
  always_comb begin
    case (alu_ctrl)
      3'b000:  alu_result = alu_srca + alu_srcb;
      3'b001:  alu_result = alu_srca << alu_srcb[4:0];
      default: alu_result = 32'hDEAD_BEEF;
    endcase
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] prod;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    n_total++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  function automatic int model_lat(input logic [31:0] b);
    int n = 0;
    int pop = 0;
    for (int i = 0; i < 32; i++) begin
      if (b[i]) begin
        n = i + 1;
        pop++;
      end
    end
    return 2 * n + pop + 1;
  endfunction

  // Counts edges until resp_valid; rnd_gnt randomizes the grant each cycle.
  task automatic wait_resp(input int start, input bit rnd_gnt, output int lat,
                           output int lows, output bit saw_req);
    lat = start;
    lows = 0;
    saw_req = 1'b0;
    while (lat < 400) begin
      @(negedge clk);
      alu_gnt = rnd_gnt ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (!alu_gnt) lows++;
      if (alu_req) saw_req = 1'b1;
      @(posedge clk);
      lat++;
      #1;
      if (resp_valid) break;
    end
    alu_gnt = 1'b1;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit rnd_gnt,
                        output logic [31:0] data, output int lat, output int lows,
                        output bit saw_req);
    @(negedge clk);
    req_a = a;
    req_b = b;
    req_valid = 1'b1;
    chk("req_ready_at_issue", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_resp(0, rnd_gnt, lat, lows, saw_req);
    data = resp_data;
  endtask

  task automatic handshake();
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t        vecs[6];
    logic [31:0] data;
    int          lat;
    int          lows;
    bit          saw;
    bit          any_resp;

    vecs[0] = '{32'd3,         32'd5,         32'd15,        9};
    vecs[1] = '{32'h1234_5678, 32'd0,         32'd0,         1};
    vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 97};
    vecs[3] = '{32'hFFFF_FFF9, 32'd6,         32'hFFFF_FFD6, 9};
    vecs[4] = '{32'd1,         32'h8000_0000, 32'h8000_0000, 66};
    vecs[5] = '{32'd7,         32'd1,         32'd7,         4};

    #2;
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_alu_req", {31'd0, alu_req}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_alu_ctrl", {29'd0, alu_ctrl}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_alu_srca", alu_srca, 32'd0);
    chk("rst_alu_srcb", alu_srcb, 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, 1'b0, data, lat, lows, saw);
      chk($sformatf("vec%0d_data", i), data, vecs[i].prod);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
      if (vecs[i].b == 32'd0) chk("zero_b_no_alu_req", {31'd0, saw}, 32'd0);
      handshake();
    end

    // Grant withheld for 4 cycles during the first ADD of 3*5.
    @(negedge clk);
    req_a = 32'd3;
    req_b = 32'd5;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 alu_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_alu_req", i), {31'd0, alu_req}, 32'd1);
      chk($sformatf("stall%0d_srca_acc", i), alu_srca, 32'd0);
      chk($sformatf("stall%0d_srcb", i), alu_srcb, 32'd3);
      chk($sformatf("stall%0d_ctrl", i), {29'd0, alu_ctrl}, 32'd0);
      @(posedge clk);
      #1;
    end
    wait_resp(5, 1'b0, lat, lows, saw);
    chk("stall_data", resp_data, 32'd15);
    chk("stall_lat", lat, 13);
    handshake();

    // Consumer back-pressure in DONE with a competing request.
    resp_ready = 1'b0;
    run_op(32'd3, 32'd5, 1'b0, data, lat, lows, saw);
    chk("bp_first_data", data, 32'd15);
    @(negedge clk);
    req_a = 32'd4;
    req_b = 32'd4;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_resp_valid", i), {31'd0, resp_valid}, 32'd1);
      chk($sformatf("bp%0d_resp_data", i), resp_data, 32'd15);
      chk($sformatf("bp%0d_req_ready", i), {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_idle_req_ready", {31'd0, req_ready}, 32'd1);
    chk("bp_idle_resp_valid", {31'd0, resp_valid}, 32'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_resp(0, 1'b0, lat, lows, saw);
    chk("bp_next_data", resp_data, 32'd16);
    chk("bp_next_lat", lat, model_lat(32'd4));
    handshake();

    // Asynchronous reset while in SHIFT.
    @(negedge clk);
    req_a = 32'd3;
    req_b = 32'd5;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("pre_rst_in_shift", {29'd0, alu_ctrl}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_alu_req", {31'd0, alu_req}, 32'd0);
    chk("arst_srca", alu_srca, 32'd0);
    chk("arst_srcb", alu_srcb, 32'd0);
    chk("arst_ctrl", {29'd0, alu_ctrl}, 32'd0);
    chk("arst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("arst_resp_data", resp_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    any_resp = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (resp_valid) any_resp = 1'b1;
    end
    chk("arst_no_response", {31'd0, any_resp}, 32'd0);
    run_op(32'd2, 32'd7, 1'b0, data, lat, lows, saw);
    chk("arst_next_data", data, 32'd14);
    chk("arst_next_lat", lat, 10);
    handshake();

    // Random operands, alternating full and random grant.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] prod;
      bit          rnd;
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      rnd = i[0];
      prod = a * b;
      run_op(a, b, rnd, data, lat, lows, saw);
      chk($sformatf("rnd%0d_data a=%h b=%h", i, a, b), data, prod);
      if (rnd) chk_range($sformatf("rnd%0d_lat", i), lat, model_lat(b), model_lat(b) + lows);
      else     chk($sformatf("rnd%0d_lat", i), lat, model_lat(b));
      handshake();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
- Multi-cycle controller that computes the low XLEN bits of a product (RV32 MUL semantics) by sequencing the shared 32-bit ALU through shift-add iterations.
- Uses ALU ADD (3'b000) and SHL (3'b001); it does not add a multiplier array.
- Sits beside the ALU, behind the datapath's ALU operand mux.
- Requests the ALU per operation through an alu_req/alu_gnt pair, and returns results over a valid/ready response channel.

Parameters:
- XLEN, 32, operand/result width; must equal ALU width.
- CTRL_ADD, 3'b000, ALUControl code for add.
- CTRL_SHL, 3'b001, ALUControl code for shift-left (by SrcB[4:0]).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  operand pair valid.
- req_ready  output  1  sequencer can accept; high only in IDLE.
- req_a  input  XLEN  multiplicand.
- req_b  input  XLEN  multiplier.
- resp_valid  output  1  result valid; high only in DONE.
- resp_ready  input  1  consumer accepts result.
- resp_data  output  XLEN  product low bits.
- alu_req  output  1  sequencer needs the ALU this cycle.
- alu_gnt  input  1  ALU operand mux is granted to sequencer this cycle.
- alu_srca  output  XLEN  ALU SrcA drive.
- alu_srcb  output  XLEN  ALU SrcB drive.
- alu_ctrl  output  3  ALU ALUControl drive.
- alu_result  input  XLEN  ALU ALUResult (combinational, same cycle).

Behaviour:
- Registers: state, acc, mcand, mplier (XLEN each), cnt (clog2(XLEN)+1 bits).
- Reset (async, rst_n=0): state=IDLE; acc, mcand, mplier, cnt=0; req_ready=1 after release; resp_valid=0; resp_data=0; alu_req=0; alu_srca=alu_srcb=0; alu_ctrl=CTRL_ADD.
- A reset mid-operation discards the operation and produces no response.
- States: IDLE, EVAL, ADD, SHIFT, DONE.
- IDLE: req_ready=1. On req_valid&&req_ready: acc<=0, mcand<=req_a, mplier<=req_b, cnt<=0, go to EVAL.
- EVAL: no ALU use.
  - If mplier==0 or cnt==XLEN, go to DONE.
  - Else if mplier[0]=1, go to ADD.
  - Else go to SHIFT.
- ADD: alu_req=1, alu_srca=acc, alu_srcb=mcand, alu_ctrl=CTRL_ADD.
  - If alu_gnt: acc<=alu_result, go to SHIFT.
  - Else hold everything (stall).
- SHIFT: alu_req=1, alu_srca=mcand, alu_srcb=1, alu_ctrl=CTRL_SHL.
  - If alu_gnt: mcand<=alu_result, mplier<=mplier>>1 (local logical shift), cnt<=cnt+1, go to EVAL.
  - Else stall.
- DONE: resp_valid=1, resp_data=acc. On resp_ready, go to IDLE. Result holds stable while resp_ready=0.
- Outside ADD/SHIFT: alu_req=0 and ALU drives are 0/0/CTRL_ADD.
- ALU outputs are combinational from state and registers; alu_req must not depend on alu_gnt.
- Arithmetic: all adds and shifts wrap mod 2^XLEN. Overflow is silent. Result is correct for signed and unsigned operands (two's-complement low bits).
- Latency with no stalls: edges from acceptance to resp_valid = 2*n + popcount(req_b) + 1, where n = index of highest set bit of req_b plus 1.
  - req_b=0 gives 1 edge.
  - req_b=0xFFFFFFFF gives 97 edges (maximum).
  - Each cycle with alu_gnt=0 in ADD/SHIFT adds exactly 1 cycle.
- Simultaneous events: req_ready is low in DONE, so a back-to-back request is accepted no earlier than the first IDLE cycle after the response handshake.
- Early termination: a multiplier of 0 skips the remaining bits.
- req_valid is ignored outside IDLE; operands are sampled only at acceptance.

Test Plan:
- a=3, b=5, alu_gnt=1, resp_ready=1: resp_data=15; resp_valid exactly 9 edges after acceptance.
- a=0x12345678, b=0: resp_data=0 after 1 edge; alu_req never asserted.
- a=0xFFFFFFFF, b=0xFFFFFFFF: resp_data=0x00000001 after 97 edges. Also check a=0xFFFFFFF9 (-7), b=6: resp_data=0xFFFFFFD6 (-42).
- a=3, b=5 with alu_gnt low for 4 cycles during first ADD: acc unchanged during stall; resp_data=15 at edge 13; alu_srca/srcb/ctrl held stable while stalled.
- resp_ready low 5 cycles in DONE: resp_valid/resp_data=15 stable; req_ready=0 and a concurrent req_valid is ignored; the new request is accepted in the IDLE cycle after the handshake.
- rst_n pulsed low in SHIFT mid-operation: all outputs take reset values immediately (async); no response emitted; the next request a=2, b=7 returns 14.
